// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding, frame data width and a counter-width helper.
// Pure declarations, no logic.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_SETTLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   // Width needed to hold values 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and ticks combinationally on the terminal count.
// Restart holds the count at zero so the first bit period after release is exactly BIT_CYCLES long.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int BIT_CYCLES = 868
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_restart,
   output logic o_tick
);

   localparam int CW = cnt_width(BIT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign o_tick = !i_restart && (cnt_q == LAST);

   // Wrapping on every tick keeps each bit exactly BIT_CYCLES long with no drift.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (i_restart || o_tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: pops one byte from an upstream FIFO and shifts it out LSB first.
// Start bit begins two cycles after the pop strobe; a queued byte restarts after a 3-cycle idle gap.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLOCK_RATE = 100000000,
   parameter int BAUD_RATE  = 115200
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_fifo_empty,
   output logic       o_fifo_read,
   input  logic [7:0] i_fifo_rdata,
   output logic       o_tx,
   output logic       o_busy
);

   localparam int BIT_CYCLES = CLOCK_RATE / BAUD_RATE;
   localparam int IW         = cnt_width(DATA_BITS);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   state_t               state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [IW-1:0]        bit_idx_q;
   logic                 tx_q;
   logic                 rd_q;
   logic                 busy_q;
   logic                 baud_restart;
   logic                 baud_tick;

   // The bit timer only runs while a frame is on the line.
   assign baud_restart = !(state_q inside {ST_START, ST_DATA, ST_STOP});

   uart_baud_gen #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_baud (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_restart(baud_restart),
      .o_tick   (baud_tick)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
         rd_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tx_q <= 1'b1;
               if (!i_fifo_empty) begin
                  state_q <= ST_READ;
                  rd_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            ST_READ: begin
               state_q <= ST_SETTLE;
               rd_q    <= 1'b0;
            end
            // FIFO output has had a full cycle to follow the pop.
            ST_SETTLE: begin
               shift_q <= i_fifo_rdata;
               state_q <= ST_START;
               tx_q    <= 1'b0;
            end
            ST_START: begin
               if (baud_tick) begin
                  state_q   <= ST_DATA;
                  bit_idx_q <= '0;
                  tx_q      <= shift_q[0];
               end
            end
            ST_DATA: begin
               if (baud_tick) begin
                  if (bit_idx_q == LAST_BIT) begin
                     state_q <= ST_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                     tx_q      <= shift_q[1];
                  end
                  shift_q <= shift_q >> 1;
               end
            end
            ST_STOP: begin
               if (baud_tick) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               tx_q    <= 1'b1;
               rd_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_tx        = tx_q;
   assign o_fifo_read = rd_q;
   assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at BIT_CYCLES=16: frame-timeline model checked every cycle, line decoder,
// FIFO model, and directed scenarios with hand-computed expectations.
module tb_uart_tx;

   localparam int CR    = 16;
   localparam int BR    = 1;
   localparam int BC    = CR / BR;
   localparam int SPAN  = 2 + 10 * BC;

   logic       i_clock      = 1'b0;
   logic       i_reset      = 1'b1;
   logic       i_fifo_empty = 1'b1;
   logic [7:0] i_fifo_rdata = 8'h00;
   logic       o_fifo_read;
   logic       o_tx;
   logic       o_busy;

   uart_tx #(
      .CLOCK_RATE(CR),
      .BAUD_RATE (BR)
   ) dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_fifo_empty(i_fifo_empty),
      .o_fifo_read (o_fifo_read),
      .i_fifo_rdata(i_fifo_rdata),
      .o_tx        (o_tx),
      .o_busy      (o_busy)
   );

   always #5 i_clock = ~i_clock;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc   = 0;
   int         pops  = 0;
   bit         chk_en = 1'b0;
   logic [7:0] fifo_q[$];
   logic [7:0] rx_q[$];
   int         rx_start[$];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(posedge i_clock) cyc++;

   // Model: a frame occupies SPAN cycles after the IDLE decision edge.
   // Phase 0 = pop strobe, 1 = settle, then 10 bit periods of BC cycles each.
   bit         m_busy = 1'b0;
   int         m_p    = 0;
   logic [7:0] m_byte = 8'h00;

   always @(posedge i_clock) begin
      if (i_reset) begin
         m_busy = 1'b0;
      end else if (!m_busy) begin
         if (fifo_q.size() != 0) begin
            m_busy = 1'b1;
            m_p    = 0;
            m_byte = fifo_q[0];
         end
      end else begin
         m_p++;
         if (m_p == SPAN) m_busy = 1'b0;
      end
   end

   function automatic int exp_tx();
      logic [2:0] bi;
      if (!m_busy || m_p < 2) return 1;
      if (m_p < 2 + BC) return 0;
      if (m_p < 2 + 9 * BC) begin
         bi = 3'((m_p - 2 - BC) / BC);
         return int'(m_byte[bi]);
      end
      return 1;
   endfunction

   always @(negedge i_clock) begin
      if (chk_en) begin
         check("tx_line", int'(o_tx), exp_tx());
         check("busy", int'(o_busy), int'(m_busy));
         check("fifo_read", int'(o_fifo_read), (m_busy && m_p == 0) ? 1 : 0);
      end
   end

   // Upstream FIFO: the popped byte appears mid-READ and is held afterwards.
   always @(negedge i_clock) begin
      if (chk_en && o_fifo_read === 1'b1) begin
         pops++;
         check("pop_nonempty", (fifo_q.size() != 0) ? 1 : 0, 1);
         if (fifo_q.size() != 0) i_fifo_rdata = fifo_q.pop_front();
         i_fifo_empty = (fifo_q.size() == 0);
      end
   end

   // Line decoder sampling mid-bit; a reset abandons any frame in progress.
   bit         rx_act   = 1'b0;
   bit         rx_abort = 1'b0;
   int         rx_cnt   = 0;
   int         rx_s     = 0;
   logic [7:0] rx_b     = 8'h00;

   always @(posedge i_clock) if (i_reset) rx_abort = 1'b1;

   always @(negedge i_clock) begin
      logic [2:0] bi;
      if (rx_abort) begin
         rx_act   = 1'b0;
         rx_abort = 1'b0;
      end else if (!rx_act) begin
         if (chk_en && o_tx === 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
            rx_s   = cyc;
            rx_b   = 8'h00;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt >= BC + BC / 2 && rx_cnt < 9 * BC && (rx_cnt - BC / 2) % BC == 0) begin
            bi = 3'((rx_cnt - BC - BC / 2) / BC);
            rx_b[bi] = o_tx;
         end
         if (rx_cnt == 9 * BC + BC / 2) begin
            check("rx_stop_bit", int'(o_tx), 1);
            rx_q.push_back(rx_b);
            rx_start.push_back(rx_s);
            rx_act = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge i_clock);
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      i_fifo_empty = 1'b0;
   endtask

   task automatic wait_rd(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge i_clock);
         if (o_fifo_read === 1'b1) begin
            at = cyc;
            break;
         end
      end
      check("wait_pop_in_time", (at >= 0) ? 1 : 0, 1);
   endtask

   task automatic wait_idle(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge i_clock);
         if (o_busy === 1'b0 && fifo_q.size() == 0) begin
            at = cyc;
            break;
         end
      end
      check("wait_idle_in_time", (at >= 0) ? 1 : 0, 1);
   endtask

   initial begin
      int p, t, p0, lows;
      logic [7:0] sent[$];

      @(negedge i_clock);
      chk_en = 1'b1;
      check("rst_tx", int'(o_tx), 1);
      check("rst_busy", int'(o_busy), 0);
      check("rst_read", int'(o_fifo_read), 0);
      tick(2);
      i_reset = 1'b0;

      // Empty FIFO: line idle, no pops.
      lows = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge i_clock);
         if (o_tx !== 1'b1) lows++;
      end
      check("empty_line_low_cycles", lows, 0);
      check("empty_pops", pops, 0);

      // Single byte 0xA3.
      p0 = pops;
      push(8'hA3);
      wait_rd(10, p);
      wait_idle(400, t);
      check("a3_start_offset", (rx_start.size() == 1) ? rx_start[0] - p : -1, 2);
      check("a3_busy_span", t - p, 162);
      check("a3_rx_count", rx_q.size(), 1);
      check("a3_rx_byte", (rx_q.size() == 1) ? int'(rx_q[0]) : -1, 'hA3);
      check("a3_pops", pops - p0, 1);
      rx_q.delete();
      rx_start.delete();

      // Back-to-back 0x01, 0x80.
      p0 = pops;
      push(8'h01);
      push(8'h80);
      wait_rd(10, p);
      wait_idle(600, t);
      check("b2b_rx_count", rx_q.size(), 2);
      check("b2b_byte0", (rx_q.size() == 2) ? int'(rx_q[0]) : -1, 'h01);
      check("b2b_byte1", (rx_q.size() == 2) ? int'(rx_q[1]) : -1, 'h80);
      check("b2b_start_gap", (rx_start.size() == 2) ? rx_start[1] - rx_start[0] : -1, 10 * BC + 3);
      check("b2b_pops", pops - p0, 2);
      rx_q.delete();
      rx_start.delete();

      // Reset inside data bit 3 of 0x55.
      p0 = pops;
      push(8'h55);
      wait_rd(10, p);
      tick(2 + BC + 3 * BC + 5);
      check("mid_busy_before_rst", int'(o_busy), 1);
      i_reset = 1'b1;
      @(negedge i_clock);
      i_reset = 1'b0;
      check("mid_rst_tx", int'(o_tx), 1);
      check("mid_rst_busy", int'(o_busy), 0);
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge i_clock);
         if (o_tx !== 1'b1) lows++;
      end
      check("mid_rst_line_high", lows, 0);
      check("mid_rst_pops", pops - p0, 1);
      check("mid_rst_no_frame", rx_q.size(), 0);

      // Reset during the READ cycle.
      p0 = pops;
      push(8'h3C);
      wait_rd(10, p);
      i_reset = 1'b1;
      @(negedge i_clock);
      i_reset = 1'b0;
      check("rd_rst_read_low", int'(o_fifo_read), 0);
      check("rd_rst_busy", int'(o_busy), 0);
      tick(200);
      check("rd_rst_pops", pops - p0, 1);
      check("rd_rst_no_frame", rx_q.size(), 0);

      // 64-byte stream, second half queued while the first is in flight.
      p0 = pops;
      for (int i = 0; i < 64; i++) sent.push_back(8'($urandom));
      for (int i = 0; i < 40; i++) push(sent[i]);
      tick(500 + $urandom_range(0, 40));
      for (int i = 40; i < 64; i++) push(sent[i]);
      wait_idle(64 * (SPAN + 5), t);
      check("stream_rx_count", rx_q.size(), 64);
      for (int i = 0; i < 64; i++)
         check("stream_byte", (i < rx_q.size()) ? int'(rx_q[i]) : -1, int'(sent[i]));
      check("stream_pops", pops - p0, 64);
      tick(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
